// File: rtl/obi_host_driver_mo_pkg.sv
// obi_host_driver_mo_pkg: shared defaults, response tag type and pointer-width helper for the OBI host driver
package obi_host_driver_mo_pkg;
    localparam int unsigned OBI_HOST_MAX_OUTSTANDING_DEFAULT = 2;
    typedef enum logic {TAG_RD = 1'b0, TAG_WR = 1'b1} rsp_tag_e;
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/obi_host_driver_mo_tag_fifo.sv
// obi_rsp_tag_fifo: parametrised-depth 1-bit in-order FIFO holding read/write tags of issued transactions
// Ports: clk_i/rst_i (sync active-high), push_i/din_i write side, pop_i read side,
//        head_o oldest entry (raw, qualify with empty_o), empty_o, full_o.
// Pointers wrap at DEPTH so non-power-of-2 depths work; push+pop at full is legal
// because head is read from the old contents while the write lands at the edge.
module obi_rsp_tag_fifo
    import obi_host_driver_mo_pkg::*;
#(
    parameter int unsigned DEPTH = OBI_HOST_MAX_OUTSTANDING_DEFAULT
)(
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic head_o,
    output logic empty_o,
    output logic full_o
);
    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (push_i) mem_d[wr_q] = din_i;
        wr_d  = push_i ? nxt(wr_q) : wr_q;
        rd_d  = pop_i ? nxt(rd_q) : rd_q;
        cnt_d = (push_i & ~pop_i) ? cnt_q + CW'(1) :
                (pop_i & ~push_i) ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
endmodule

// File: rtl/obi_host_driver_mo.sv
// obi_host_driver_mo: OBI host request/stall driver with up to MAX_OUTSTANDING in-order transactions
// Ports: clk_i/rst_i (sync active-high); rd_i/wr_i/fence_i from the pipeline; gnt_i/rvalid_i from OBI;
//        req_o OBI request, stall_o pipeline stall, rsp_is_wr_o head tag (with rvalid_i),
//        outstanding_o count, spurious_o unexpected-response pulse, timeout_o sticky watchdog flag.
// Optional watchdog enabled by defining OBI_HOST_TIMEOUT_EN; otherwise timeout_o is tied low.
module obi_host_driver_mo
    import obi_host_driver_mo_pkg::*;
#(
    parameter  int unsigned MAX_OUTSTANDING = OBI_HOST_MAX_OUTSTANDING_DEFAULT,
    parameter  int unsigned TIMEOUT_CYCLES  = 256,
    localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rd_i,
    input  logic             wr_i,
    input  logic             fence_i,
    input  logic             gnt_i,
    input  logic             rvalid_i,
    output logic             req_o,
    output logic             stall_o,
    output logic             rsp_is_wr_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             spurious_o,
    output logic             timeout_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             any_req, busy, retire, full, issue;
    logic             tag_head, tag_empty, tag_full;
    rsp_tag_e         push_tag;

    assign any_req = rd_i | wr_i;
    assign busy    = cnt_q != '0;
    assign retire  = rvalid_i & busy;
    // A response arriving this cycle frees a slot, so full is relaxed combinationally.
    assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING)) & ~rvalid_i;
    assign req_o   = ~rst_i & any_req & ~full & ~(fence_i & busy);
    assign issue   = req_o & gnt_i;
    // Fence stall looks at the post-retire count so it releases in the draining cycle.
    assign stall_o = ~rst_i & ((any_req & ~issue) | (fence_i & ((cnt_q - CNT_W'(retire)) != '0)));
    assign spurious_o    = ~rst_i & rvalid_i & ~busy;
    assign outstanding_o = cnt_q;
    assign push_tag      = wr_i ? TAG_WR : TAG_RD;
    assign rsp_is_wr_o   = tag_head & ~tag_empty;

    always_comb begin
        cnt_d = (issue & ~retire) ? cnt_q + CNT_W'(1) :
                (retire & ~issue) ? cnt_q - CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    obi_rsp_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue),
        .pop_i   (retire),
        .din_i   (push_tag),
        .head_o  (tag_head),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(rd_i && wr_i)) else $error("rd_i and wr_i asserted together");
            assert (!(issue && !retire && tag_full)) else $error("tag FIFO overflow");
        end
    end

`ifdef OBI_HOST_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;

    always_comb begin
        wd_d = (~busy | retire) ? '0 :
               (wd_q == WD_W'(TIMEOUT_CYCLES)) ? wd_q : wd_q + WD_W'(1);
        to_d = to_q | (wd_d == WD_W'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout_o = to_q;
`else
    assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_obi_host_driver_mo.sv
// tb_obi_host_driver_mo: directed scoreboard bench for obi_host_driver_mo (MAX_OUTSTANDING=2, TIMEOUT_CYCLES=8)
module tb_obi_host_driver_mo;
    logic       clk_i = 1'b0, rst_i = 1'b1;
    logic       rd_i = 1'b0, wr_i = 1'b0, fence_i = 1'b0, gnt_i = 1'b0, rvalid_i = 1'b0;
    logic       req_o, stall_o, rsp_is_wr_o, spurious_o, timeout_o;
    logic [1:0] outstanding_o;
    int         checks = 0, failures = 0;
    logic       exp_q[$];

`ifdef OBI_HOST_TIMEOUT_EN
    localparam int TO_EN = 1;
`else
    localparam int TO_EN = 0;
`endif

    always #5 clk_i = ~clk_i;

    obi_host_driver_mo #(.MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rd_i          (rd_i),
        .wr_i          (wr_i),
        .fence_i       (fence_i),
        .gnt_i         (gnt_i),
        .rvalid_i      (rvalid_i),
        .req_o         (req_o),
        .stall_o       (stall_o),
        .rsp_is_wr_o   (rsp_is_wr_o),
        .outstanding_o (outstanding_o),
        .spurious_o    (spurious_o),
        .timeout_o     (timeout_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic r, input logic w, input logic f,
                         input logic g, input logic v);
        @(posedge clk_i);
        #1;
        rst_i = rst; rd_i = r; wr_i = w; fence_i = f; gnt_i = g; rvalid_i = v;
        @(negedge clk_i);
    endtask

    // Scoreboard monitor: every accepted response must carry the oldest expected tag.
    always @(negedge clk_i)
        if (!rst_i && rvalid_i && exp_q.size() != 0)
            chk("rsp_tag", int'(rsp_is_wr_o), int'(exp_q.pop_front()));

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        drive(1, 1, 0, 0, 1, 0);
        chk("rst_req", req_o, 0);
        chk("rst_stall", stall_o, 0);
        drive(1, 1, 0, 0, 1, 1);
        chk("rst_spur", spurious_o, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_cnt", outstanding_o, 0);
        chk("rst_tag", rsp_is_wr_o, 0);
        chk("rst_to", timeout_o, 0);

        drive(0, 1, 0, 0, 1, 0); exp_q.push_back(1'b0);
        chk("pipe_req0", req_o, 1);
        chk("pipe_stall0", stall_o, 0);
        drive(0, 1, 0, 0, 1, 0); exp_q.push_back(1'b0);
        chk("pipe_cnt1", outstanding_o, 1);
        chk("pipe_req1", req_o, 1);
        drive(0, 1, 0, 0, 1, 0);
        chk("pipe_cnt_full", outstanding_o, 2);
        chk("pipe_req_full", req_o, 0);
        chk("pipe_stall_full", stall_o, 1);
        drive(0, 1, 0, 0, 1, 0);
        chk("pipe_req_full2", req_o, 0);
        drive(0, 1, 0, 0, 1, 1); exp_q.push_back(1'b0);
        chk("pipe_bypass_req", req_o, 1);
        chk("pipe_bypass_stall", stall_o, 0);
        chk("pipe_bypass_cnt", outstanding_o, 2);
        drive(0, 0, 0, 0, 0, 1);
        chk("pipe_drain_cnt2", outstanding_o, 2);
        drive(0, 0, 0, 0, 0, 1);
        chk("pipe_drain_cnt1", outstanding_o, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("pipe_drain_cnt0", outstanding_o, 0);

        drive(0, 0, 1, 0, 1, 0); exp_q.push_back(1'b1);
        chk("mix_req_w", req_o, 1);
        drive(0, 1, 0, 0, 1, 0); exp_q.push_back(1'b0);
        chk("mix_cnt1", outstanding_o, 1);
        drive(0, 0, 1, 0, 1, 1); exp_q.push_back(1'b1);
        chk("mix_cnt2", outstanding_o, 2);
        chk("mix_req_bypass", req_o, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("mix_cnt2b", outstanding_o, 2);
        drive(0, 0, 0, 0, 0, 1);
        chk("mix_cnt1b", outstanding_o, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("mix_cnt0", outstanding_o, 0);
        chk("mix_tag_empty", rsp_is_wr_o, 0);

        drive(0, 1, 0, 0, 1, 0); exp_q.push_back(1'b0);
        drive(0, 1, 0, 0, 1, 0); exp_q.push_back(1'b0);
        drive(0, 1, 0, 1, 1, 0);
        chk("fence_cnt", outstanding_o, 2);
        chk("fence_req", req_o, 0);
        chk("fence_stall", stall_o, 1);
        drive(0, 1, 0, 1, 1, 1);
        chk("fence_req_rv1", req_o, 0);
        chk("fence_stall_rv1", stall_o, 1);
        drive(0, 0, 0, 1, 1, 1);
        chk("fence_cnt_rv2", outstanding_o, 1);
        chk("fence_stall_rv2", stall_o, 0);
        chk("fence_req_rv2", req_o, 0);
        drive(0, 1, 0, 1, 1, 0); exp_q.push_back(1'b0);
        chk("fence_cnt_done", outstanding_o, 0);
        chk("fence_req_done", req_o, 1);
        chk("fence_stall_done", stall_o, 0);
        drive(0, 0, 0, 0, 0, 1);
        chk("fence_cnt_tail", outstanding_o, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("fence_cnt_end", outstanding_o, 0);

        drive(0, 1, 0, 0, 1, 0); exp_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 1, 1); exp_q.push_back(1'b0);
            chk("b2b_req", req_o, 1);
            chk("b2b_stall", stall_o, 0);
            chk("b2b_cnt", outstanding_o, 1);
        end
        drive(0, 0, 0, 0, 0, 1);
        chk("b2b_cnt_tail", outstanding_o, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("b2b_cnt_end", outstanding_o, 0);

        drive(0, 0, 0, 0, 0, 1);
        chk("spur_pulse", spurious_o, 1);
        chk("spur_cnt", outstanding_o, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("spur_clear", spurious_o, 0);
        chk("spur_cnt2", outstanding_o, 0);

        drive(0, 1, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 1, 0);
        exp_q.delete();
        drive(1, 1, 0, 0, 1, 0);
        chk("midrst_req", req_o, 0);
        chk("midrst_stall", stall_o, 0);
        drive(0, 0, 0, 0, 0, 1);
        chk("midrst_cnt", outstanding_o, 0);
        chk("midrst_spur", spurious_o, 1);
        drive(0, 0, 0, 0, 0, 0);

        drive(0, 1, 0, 0, 1, 0); exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0);
        chk("to_early", timeout_o, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0);
        chk("to_fire", timeout_o, TO_EN);
        chk("to_cnt", outstanding_o, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("to_sticky", timeout_o, TO_EN);
        chk("to_cnt0", outstanding_o, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("to_reset", timeout_o, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
